// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the counter-width function.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_add_stage.sv
// WIDTH-bit ripple-carry adder built from full_adder cells.
// Carry-in is tied low; the carry-out feeds the accumulator top bit.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module mult_add_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_c[i]),
            .o_s    (o_sum[i]),
            .o_cout (w_c[i+1])
        );
    end

    assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one add per cycle.
// Optional MUL_ZERO_BYPASS_EN skips CALC when an operand is zero.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_shift;

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_shift = {w_cout, w_sum, r_mplier[WIDTH-1:1]};

    // Control FSM plus accumulator/multiplier shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                        if (a == '0 || b == '0) begin
                            r_product <= '0;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_shift[2*WIDTH-1:WIDTH];
                    r_mplier <= w_shift[WIDTH-1:0];
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_product <= w_shift;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=4.
// Expectations follow MUL_ZERO_BYPASS_EN when it is defined.
module tb_seq_shift_add_mult;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_cmp;
    int n_fail;
    int cyc_cnt;

    seq_shift_add_mult #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [3:0] x, input logic [3:0] y);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int lat0;
        int last_t;
        int exp_sp;
        bit seen;
        logic [7:0] exp_p;

        n_cmp = 0;
        n_fail = 0;
        cyc_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_prod", 32'(product), 0);
        rst_n = 1'b1;
        tick();

        launch(4'd3, 4'd5);
        chk("t1_busy0", 32'(busy), 1);
        chk("t1_done0", 32'(done), 0);
        chk("t1_prod_hold", 32'(product), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_busy_calc", 32'(busy), 1);
            chk("t1_no_done", 32'(done), 0);
            chk("t1_prod_mid", 32'(product), 0);
        end
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_done", 32'(busy), 1);
        chk("t1_prod", 32'(product), 15);
        tick();
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_done_end", 32'(done), 0);
        chk("t1_prod_keep", 32'(product), 15);

        launch(4'd15, 4'd15);
        wait_done(cyc);
        chk("t2_lat", 32'(cyc), 4);
        chk("t2_prod", 32'(product), 8'hE1);
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        tick();
        chk("t2_done_fall", 32'(done), 0);
        chk("t2_idle_busy", 32'(busy), 0);
        tick();
        start = 1'b0;
        chk("t2_relaunch", 32'(busy), 1);
        chk("t2_hold225", 32'(product), 8'hE1);
        wait_done(cyc);
        chk("t2b_lat", 32'(cyc), 4);
        chk("t2b_prod", 32'(product), 1);
        tick();

        launch(4'd0, 4'd9);
        wait_done(cyc);
`ifdef MUL_ZERO_BYPASS_EN
        lat0 = 0;
`else
        lat0 = 4;
`endif
        chk("t3_lat", 32'(cyc), 32'(lat0));
        chk("t3_done", 32'(done), 1);
        chk("t3_prod", 32'(product), 0);
        tick();

        launch(4'd7, 4'd6);
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("t4_lat", 32'(cyc), 1);
        chk("t4_prod", 32'(product), 42);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("t4_single", 32'(seen), 0);
        chk("t4_prod_keep", 32'(product), 42);

        launch(4'd9, 4'd9);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_prod", 32'(product), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("t5_no_done", 32'(seen), 0);
        launch(4'd2, 4'd3);
        wait_done(cyc);
        chk("t5_prod6", 32'(product), 6);
        tick();
        tick();

        start = 1'b1;
        last_t = 0;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            exp_p = 8'(a) * 8'(b);
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (done !== 1'b1 && cyc < 20);
            chk("sw_timeout", 32'(done), 1);
            chk("sw_prod", 32'(product), 32'(exp_p));
`ifdef MUL_ZERO_BYPASS_EN
            exp_sp = (a == 0 || b == 0) ? 2 : 6;
`else
            exp_sp = 6;
`endif
            if (i > 0) chk("sw_spacing", 32'(cyc_cnt - last_t), 32'(exp_sp));
            last_t = cyc_cnt;
        end
        start = 1'b0;
        tick();
        tick();
        chk("sw_end_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
